// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD path: the 17-bit FIFO word format,
// the frame-start marker and the RGB565 colour-bar palette.
package lcd_pkg;

    // Bit 16 flags a frame-start marker, bits [15:0] carry an RGB565 pixel.
    typedef logic [16:0] queue_word_t;

    localparam queue_word_t FRAME_MARKER = 17'h10000;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Classic eight-bar palette, brightest on the left, black on the right.
    function automatic logic [15:0] bar_colour(input logic [2:0] barIdx);
        logic [15:0] colour;
        case (barIdx)
            3'd0:    colour = RGB_WHITE;
            3'd1:    colour = RGB_YELLOW;
            3'd2:    colour = RGB_CYAN;
            3'd3:    colour = RGB_GREEN;
            3'd4:    colour = RGB_MAGENTA;
            3'd5:    colour = RGB_RED;
            3'd6:    colour = RGB_BLUE;
            default: colour = RGB_BLACK;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/debug_pattern_generator.sv
// Free-running colour-bar source that feeds the LCD FIFO with the same
// word format as the camera stream, so the display side can be brought up
// on its own. A frame is one marker word followed by WIDTH*HEIGHT pixels.
module debug_pattern_generator
    import lcd_pkg::*;
#(
    parameter int FRAME_WIDTH  = 480,
    parameter int FRAME_HEIGHT = 272
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        queue_full,
    output logic [16:0] queue_data,
    output logic        queue_wr_en
);

    localparam int BAR_W = FRAME_WIDTH / 8;
    localparam int XW    = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int BW    = (BAR_W        > 1) ? $clog2(BAR_W)        : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_HEIGHT - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic {
        MARKER,
        PIXELS
    } state_t;

    state_t      state_q,  state_d;
    logic [XW-1:0] x_q,    x_d;
    logic [YW-1:0] y_q,    y_d;
    logic [BW-1:0] barCnt_q, barCnt_d;
    logic [2:0]  barIdx_q, barIdx_d;
    queue_word_t word_q,   word_d;
    logic        active_q;

    // The generator only writes once it has seen a clock edge out of reset,
    // and never while the FIFO reports full, so no word is lost or doubled.
    assign queue_wr_en = active_q && !queue_full;
    assign queue_data  = word_q;

    // Marks the first edge after reset release; cleared instantly by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    // Pattern state register; everything only moves on an accepted write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= MARKER;
            x_q      <= '0;
            y_q      <= '0;
            barCnt_q <= '0;
            barIdx_q <= '0;
            word_q   <= FRAME_MARKER;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            barCnt_q <= barCnt_d;
            barIdx_q <= barIdx_d;
            word_q   <= word_d;
        end
    end

    // Next-word logic: counts pixels and bars and preloads the next word,
    // using a per-bar counter so no division is needed to find the bar.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        barCnt_d = barCnt_q;
        barIdx_d = barIdx_q;
        word_d   = word_q;

        if (queue_wr_en) begin
            case (state_q)
                MARKER: begin
                    state_d = PIXELS;
                    word_d  = {1'b0, bar_colour(3'd0)};
                end
                default: begin
                    if (x_q == X_LAST) begin
                        x_d      = '0;
                        barCnt_d = '0;
                        barIdx_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = MARKER;
                            word_d  = FRAME_MARKER;
                        end else begin
                            y_d    = y_q + 1'b1;
                            word_d = {1'b0, bar_colour(3'd0)};
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        if (barCnt_q == BAR_LAST) begin
                            barCnt_d = '0;
                            barIdx_d = barIdx_q + 1'b1;
                        end else begin
                            barCnt_d = barCnt_q + 1'b1;
                        end
                        word_d = {1'b0, bar_colour(barIdx_d)};
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_pattern_generator.sv
// Directed bench for the colour-bar generator. A short frame height keeps
// whole-frame and multi-frame runs small while the line width stays 480.
module tb_debug_pattern_generator;

    localparam int W      = 480;
    localparam int H      = 4;
    localparam int PERIOD = 1 + W * H;

    logic        clk;
    logic        reset_n;
    logic        queue_full;
    logic [16:0] queue_data;
    logic        queue_wr_en;

    int assertCount;
    int failCount;
    int unsigned wordIdx;

    logic [15:0] colourTbl [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                   16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    debug_pattern_generator #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .queue_full (queue_full),
        .queue_data (queue_data),
        .queue_wr_en(queue_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference word for stream position idx counted from reset release.
    function automatic logic [16:0] expWord(input int unsigned idx);
        int unsigned k;
        int unsigned x;
        k = idx % PERIOD;
        if (k == 0) return 17'h10000;
        x = (k - 1) % W;
        return {1'b0, colourTbl[x / (W / 8)]};
    endfunction

    // One clock: set queue_full on the falling edge, then sample what the
    // next rising edge will transfer.
    task automatic cycle(input logic full, output logic we, output logic [16:0] d);
        @(negedge clk);
        queue_full = full;
        #1;
        we = queue_wr_en;
        d  = queue_data;
    endtask

    task automatic test_reset();
        logic we;
        logic [16:0] d;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, we, d);
            assertCount++;
            if (we !== 1'b0 || d !== 17'h10000) begin
                failCount++;
                $display("[TB] FAIL reset_hold: wr_en=%b data=%h, want wr_en=0 data=10000", we, d);
            end
        end
        reset_n = 1'b1;
        wordIdx = 0;
        cycle(1'b0, we, d);
        assertCount++;
        if (we !== 1'b1 || d !== 17'h10000) begin
            failCount++;
            $display("[TB] FAIL first_marker: wr_en=%b data=%h, want wr_en=1 data=10000", we, d);
        end
        if (we === 1'b1) wordIdx++;
        cycle(1'b0, we, d);
        assertCount++;
        if (we !== 1'b1 || d !== 17'h0FFFF) begin
            failCount++;
            $display("[TB] FAIL first_pixel: wr_en=%b data=%h, want wr_en=1 data=0ffff", we, d);
        end
        if (we === 1'b1) wordIdx++;
    endtask

    // Pixels 1..58 and then a ten-cycle stall while pixel 59 is presented.
    task automatic test_stall();
        logic we;
        logic [16:0] d;
        while (wordIdx < 60) begin
            cycle(1'b0, we, d);
            assertCount++;
            if (we !== 1'b1 || d !== expWord(wordIdx)) begin
                failCount++;
                $display("[TB] FAIL pre_stall idx %0d: wr_en=%b data=%h, want wr_en=1 data=%h",
                         wordIdx, we, d, expWord(wordIdx));
            end
            wordIdx++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, we, d);
            assertCount++;
            if (we !== 1'b0 || d !== 17'h0FFFF) begin
                failCount++;
                $display("[TB] FAIL stall_hold: wr_en=%b data=%h, want wr_en=0 data=0ffff", we, d);
            end
        end
        cycle(1'b0, we, d);
        assertCount++;
        if (we !== 1'b1 || d !== 17'h0FFFF) begin
            failCount++;
            $display("[TB] FAIL stall_resume_59: wr_en=%b data=%h, want wr_en=1 data=0ffff", we, d);
        end
        cycle(1'b0, we, d);
        assertCount++;
        if (we !== 1'b1 || d !== 17'h0FFE0) begin
            failCount++;
            $display("[TB] FAIL stall_resume_60: wr_en=%b data=%h, want wr_en=1 data=0ffe0", we, d);
        end
        wordIdx = 62;
    endtask

    // Remaining bars of line 0 and the first pixel of line 1.
    task automatic test_bars();
        logic we;
        logic [16:0] d;
        while (wordIdx <= 481) begin
            cycle(1'b0, we, d);
            assertCount++;
            if (we !== 1'b1 || d !== expWord(wordIdx)) begin
                failCount++;
                $display("[TB] FAIL bars idx %0d: wr_en=%b data=%h, want wr_en=1 data=%h",
                         wordIdx, we, d, expWord(wordIdx));
            end
            if (wordIdx == 421) begin
                assertCount++;
                if (d !== 17'h00000) begin
                    failCount++;
                    $display("[TB] FAIL black_bar_start: data=%h, want 00000", d);
                end
            end
            if (wordIdx == 481) begin
                assertCount++;
                if (d !== 17'h0FFFF) begin
                    failCount++;
                    $display("[TB] FAIL line1_x0: data=%h, want 0ffff", d);
                end
            end
            wordIdx++;
        end
    endtask

    // Rest of frame 0, the next marker and the first pixel of frame 1.
    task automatic test_full_frame();
        logic we;
        logic [16:0] d;
        while (wordIdx <= 1 + W * H + 1) begin
            cycle(1'b0, we, d);
            assertCount++;
            if (we !== 1'b1 || d !== expWord(wordIdx)) begin
                failCount++;
                $display("[TB] FAIL frame idx %0d: wr_en=%b data=%h, want wr_en=1 data=%h",
                         wordIdx, we, d, expWord(wordIdx));
            end
            if (wordIdx == 1 + W * H) begin
                assertCount++;
                if (d !== 17'h10000) begin
                    failCount++;
                    $display("[TB] FAIL frame_end_marker: data=%h, want 10000", d);
                end
            end
            wordIdx++;
        end
    endtask

    // Two frames with random back-pressure; every written word must match.
    task automatic test_back_to_back();
        logic we;
        logic [16:0] d;
        logic full;
        int unsigned target;
        int cycles;
        target = wordIdx + 2 * PERIOD;
        cycles = 0;
        while (wordIdx < target && cycles < 40000) begin
            full = 1'($urandom_range(0, 1));
            cycle(full, we, d);
            cycles++;
            if (full) begin
                assertCount++;
                if (we !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL bp_wr_while_full: wr_en=%b, want 0", we);
                end
            end else begin
                assertCount++;
                if (we !== 1'b1 || d !== expWord(wordIdx)) begin
                    failCount++;
                    $display("[TB] FAIL bp idx %0d: wr_en=%b data=%h, want wr_en=1 data=%h",
                             wordIdx, we, d, expWord(wordIdx));
                end
                wordIdx++;
            end
        end
        assertCount++;
        if (wordIdx < target) begin
            failCount++;
            $display("[TB] FAIL bp_timeout: words=%0d, want %0d", wordIdx, target);
        end
    endtask

    // Asynchronous reset at pixel 1000, then restart with a marker.
    task automatic test_midframe_reset();
        logic we;
        logic [16:0] d;
        int cycles;
        while ((wordIdx % PERIOD) != 1001) begin
            cycle(1'b0, we, d);
            if (we === 1'b1) wordIdx++;
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        assertCount++;
        if (queue_wr_en !== 1'b0 || queue_data !== 17'h10000) begin
            failCount++;
            $display("[TB] FAIL async_reset: wr_en=%b data=%h, want wr_en=0 data=10000",
                     queue_wr_en, queue_data);
        end
        cycle(1'b0, we, d);
        reset_n = 1'b1;
        cycles = 0;
        we = 1'b0;
        while (we !== 1'b1 && cycles < 10) begin
            cycle(1'b0, we, d);
            cycles++;
        end
        assertCount++;
        if (we !== 1'b1 || d !== 17'h10000) begin
            failCount++;
            $display("[TB] FAIL restart_marker: wr_en=%b data=%h, want wr_en=1 data=10000", we, d);
        end
        cycle(1'b0, we, d);
        assertCount++;
        if (we !== 1'b1 || d !== 17'h0FFFF) begin
            failCount++;
            $display("[TB] FAIL restart_pixel: wr_en=%b data=%h, want wr_en=1 data=0ffff", we, d);
        end
    endtask

    // Scenario sequence.
    initial begin
        assertCount = 0;
        failCount   = 0;
        wordIdx     = 0;
        reset_n     = 1'b0;
        queue_full  = 1'b0;
        test_reset();
        test_stall();
        test_bars();
        test_full_frame();
        test_back_to_back();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
